// File: rtl/spike_maxpool_2d_unit_pkg.sv
// spike_maxpool_2d_unit_pkg: shared encodings and column slicing for the spike max-pool unit (optional 3x3 mode: MAXPOOL_K3_MODE_EN)
`ifndef IMG_WIDTH
`define IMG_WIDTH 8
`endif
`ifndef TIME_STEPS
`define TIME_STEPS 4
`endif
`define SPK_COL(c, w) (c)*(w) +: (w)

package spike_maxpool_2d_unit_pkg;
    localparam logic POOL_2X2 = 1'b0;
    localparam logic POOL_3X3 = 1'b1;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
endpackage

// File: rtl/spike_maxpool_2d_unit_hpool.sv
// spike_hpool_reduce: combinational horizontal OR reduce of one spike row with column masking
module spike_hpool_reduce
    import spike_maxpool_2d_unit_pkg::*;
#(
    parameter int IMG_WIDTH  = `IMG_WIDTH,
    parameter int TIME_STEPS = `TIME_STEPS
) (
    input  logic [IMG_WIDTH*TIME_STEPS-1:0]     row_data,
    input  logic [15:0]                         img_size,
    input  logic                                mode,
    output logic [(IMG_WIDTH/2)*TIME_STEPS-1:0] hrow
);
    logic [IMG_WIDTH*TIME_STEPS-1:0] masked;
    genvar c, j;
    for (c = 0; c < IMG_WIDTH; c++) begin : g_mask
        assign masked[`SPK_COL(c, TIME_STEPS)] = (16'(c) < img_size) ? row_data[`SPK_COL(c, TIME_STEPS)] : '0;
    end
    for (j = 0; j < IMG_WIDTH/2; j++) begin : g_out
        logic [TIME_STEPS-1:0] left;
        if (j == 0) begin : g_edge
            assign left = '0;
        end else begin : g_mid
            assign left = (mode == POOL_3X3) ? masked[`SPK_COL(2*j-1, TIME_STEPS)] : '0;
        end
        assign hrow[`SPK_COL(j, TIME_STEPS)] = (16'(j) < {1'b0, img_size[15:1]})
            ? (left | masked[`SPK_COL(2*j, TIME_STEPS)] | masked[`SPK_COL(2*j+1, TIME_STEPS)]) : '0;
    end
endmodule

// File: rtl/spike_maxpool_2d_unit.sv
// spike_maxpool_2d_unit: row-streaming 2x2/3x3 stride-2 spike max-pool (3x3 mode only with MAXPOOL_K3_MODE_EN)
module spike_maxpool_2d_unit
    import spike_maxpool_2d_unit_pkg::*;
#(
    parameter int IMG_WIDTH  = `IMG_WIDTH,
    parameter int TIME_STEPS = `TIME_STEPS,
    parameter int CH_W       = 16
) (
    input  logic                                s_clk,
    input  logic                                s_rst_n,
    input  logic                                code_valid,
    input  logic [15:0]                         conv_in_ch,
    input  logic [15:0]                         conv_img_size,
    input  logic                                pool_mode,
    input  logic                                i_row_valid,
    output logic                                o_row_ready,
    input  logic [IMG_WIDTH*TIME_STEPS-1:0]     i_row_data,
    output logic                                o_pool_valid,
    input  logic                                i_pool_ready,
    output logic [(IMG_WIDTH/2)*TIME_STEPS-1:0] o_pool_data,
    output logic                                o_busy,
    output logic                                o_layer_done
);
    localparam int OW = (IMG_WIDTH/2)*TIME_STEPS;
    logic [1:0]      state;
    logic [15:0]     ch_cfg, size_cfg, r;
    logic [CH_W-1:0] ch, ch_last;
    logic [OW-1:0]   acc, hrow;
    logic            mode_eff, xfer, last_row;
`ifdef MAXPOOL_K3_MODE_EN
    logic mode_cfg;
    assign mode_eff = mode_cfg;
    // pool mode is captured with the rest of the layer config
    always_ff @(posedge s_clk or negedge s_rst_n)
        if (!s_rst_n) mode_cfg <= POOL_2X2;
        else if (state == ST_IDLE && code_valid) mode_cfg <= pool_mode;
`else
    logic unused_mode;
    assign unused_mode = pool_mode;
    assign mode_eff = POOL_2X2;
`endif
    assign ch_last     = CH_W'((ch_cfg == 16'd0) ? 16'd1 : ch_cfg) - CH_W'(1);
    assign o_row_ready = (state == ST_RUN) && (!o_pool_valid || i_pool_ready);
    assign xfer        = i_row_valid && o_row_ready;
    assign last_row    = r == size_cfg - 16'd1;
    assign o_busy      = state != ST_IDLE;
    spike_hpool_reduce #(.IMG_WIDTH(IMG_WIDTH), .TIME_STEPS(TIME_STEPS)) u_hpool (
        .row_data(i_row_data),
        .img_size(size_cfg),
        .mode    (mode_eff),
        .hrow    (hrow)
    );
    // layer FSM, row/channel counters, vertical accumulator and output register
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state        <= ST_IDLE;
            ch_cfg       <= '0;
            size_cfg     <= '0;
            r            <= '0;
            ch           <= '0;
            acc          <= '0;
            o_pool_data  <= '0;
            o_pool_valid <= 1'b0;
            o_layer_done <= 1'b0;
        end else begin
            o_layer_done <= 1'b0;
            if (o_pool_valid && i_pool_ready) o_pool_valid <= 1'b0;
            if (state == ST_IDLE && code_valid) begin
                state    <= ST_RUN;
                ch_cfg   <= conv_in_ch;
                size_cfg <= conv_img_size;
                r        <= '0;
                ch       <= '0;
                acc      <= '0;
            end
            if (state == ST_DRAIN && !o_pool_valid) begin
                state        <= ST_IDLE;
                o_layer_done <= 1'b1;
            end
            if (xfer) begin
                r <= last_row ? 16'd0 : r + 16'd1;
                if (!r[0]) acc <= acc | hrow;
                else begin
                    o_pool_data  <= acc | hrow;
                    o_pool_valid <= 1'b1;
                    acc          <= (mode_eff == POOL_3X3 && !last_row) ? hrow : '0;
                end
                if (last_row) begin
                    ch <= ch + CH_W'(1);
                    if (ch == ch_last) state <= ST_DRAIN;
                end
            end
        end
    end
endmodule

// File: tb/tb_spike_maxpool_2d_unit.sv
// tb_spike_maxpool_2d_unit: randomized self-checking bench against a window-level OR reference model
module tb_spike_maxpool_2d_unit;
    logic        s_clk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        code_valid = 1'b0;
    logic [15:0] conv_in_ch = '0;
    logic [15:0] conv_img_size = '0;
    logic        pool_mode = 1'b0;
    logic        i_row_valid = 1'b0;
    logic        o_row_ready;
    logic [31:0] i_row_data = '0;
    logic        o_pool_valid;
    logic        i_pool_ready = 1'b0;
    logic [15:0] o_pool_data;
    logic        o_busy;
    logic        o_layer_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] img [0:2][0:7];
    logic [15:0] expq [$];

    spike_maxpool_2d_unit #(.IMG_WIDTH(8), .TIME_STEPS(4), .CH_W(16)) dut (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .code_valid(code_valid), .conv_in_ch(conv_in_ch),
        .conv_img_size(conv_img_size), .pool_mode(pool_mode), .i_row_valid(i_row_valid),
        .o_row_ready(o_row_ready), .i_row_data(i_row_data), .o_pool_valid(o_pool_valid),
        .i_pool_ready(i_pool_ready), .o_pool_data(o_pool_data), .o_busy(o_busy),
        .o_layer_done(o_layer_done)
    );

    always #5 s_clk = ~s_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pix(int m, int y, int x, int sz);
        logic [31:0] w;
        if (y < 0 || y >= sz || x < 0 || x >= sz) return 4'h0;
        w = img[m][y];
        return w[x*4 +: 4];
    endfunction

    task automatic build_expected(input int nm, input int sz, input bit k3);
        logic [15:0] word;
        logic [3:0]  v;
        expq.delete();
        for (int m = 0; m < nm; m++)
            for (int i = 0; i < sz/2; i++) begin
                word = '0;
                for (int j = 0; j < sz/2; j++) begin
                    v = '0;
                    for (int dy = (k3 ? -1 : 0); dy <= 1; dy++)
                        for (int dx = (k3 ? -1 : 0); dx <= 1; dx++)
                            v |= pix(m, 2*i+dy, 2*j+dx, sz);
                    word[j*4 +: 4] = v;
                end
                expq.push_back(word);
            end
    endtask

    task automatic fill_rand();
        for (int m = 0; m < 3; m++)
            for (int y = 0; y < 8; y++) img[m][y] = $urandom;
    endtask

    task automatic fill_zero();
        for (int m = 0; m < 3; m++)
            for (int y = 0; y < 8; y++) img[m][y] = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, o_pool_valid, 0);
        check({tag, "_ready"}, o_row_ready, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_layer_done, 0);
        check({tag, "_data"}, o_pool_data, 0);
    endtask

    // rdy_mode: 0 always ready, 1 stall 5 cycles on first output, 2 random
    task automatic run_layer(input int ch, input int sz, input bit md, input int rdy_mode,
                             input bit gaps, input int abort);
        int nm, total, sent, got, done, cyc, exp_n, hold_cnt;
        bit k3, held;
        logic [15:0] held_data, e;
        nm = (ch == 0) ? 1 : ch;
`ifdef MAXPOOL_K3_MODE_EN
        k3 = md;
`else
        k3 = 1'b0;
`endif
        build_expected(nm, sz, k3);
        exp_n = expq.size();
        total = nm * sz;
        sent = 0; got = 0; done = 0; cyc = 0; hold_cnt = 0; held = 0; held_data = '0;
        @(negedge s_clk);
        code_valid = 1'b1; conv_in_ch = 16'(ch); conv_img_size = 16'(sz); pool_mode = md;
        i_row_valid = 1'b0; i_pool_ready = 1'b1;
        @(negedge s_clk);
        code_valid = 1'b0;
        #1;
        check("run_entry_busy", o_busy, 1);
        check("run_entry_ready", o_row_ready, 1);
        while (cyc < 2000 && done == 0) begin
            if (abort > 0 && sent == abort) break;
            if (rdy_mode == 0) i_pool_ready = 1'b1;
            else if (rdy_mode == 1) begin
                i_pool_ready = !(o_pool_valid && got == 0 && hold_cnt < 5);
                if (!i_pool_ready) hold_cnt++;
            end else i_pool_ready = $urandom_range(0, 2) != 0;
            i_row_valid = (sent < total) && (!gaps || $urandom_range(0, 3) != 0);
            i_row_data = i_row_valid ? img[sent/sz][sent%sz] : $urandom;
            if (gaps && sent < total) begin
                code_valid = $urandom_range(0, 1) == 1;
                conv_img_size = 16'($urandom_range(1, 4) * 2);
                conv_in_ch = 16'($urandom_range(0, 3));
                pool_mode = $urandom_range(0, 1) == 1;
            end else code_valid = 1'b0;
            #1;
            if (held) begin
                check("hold_valid", o_pool_valid, 1);
                check("hold_data", o_pool_data, held_data);
            end
            held = 0;
            if (o_pool_valid && !i_pool_ready) begin
                check("stall_row_ready", o_row_ready, 0);
                held = 1;
                held_data = o_pool_data;
            end
            if (o_pool_valid && i_pool_ready) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check($sformatf("out_m%0d_r%0d", got/(sz/2), got%(sz/2)), o_pool_data, e);
                end else check("extra_out", o_pool_valid, 0);
                got++;
            end
            if (i_row_valid && o_row_ready) sent++;
            if (o_layer_done) begin
                done++;
                check("done_busy", o_busy, 0);
                check("done_valid", o_pool_valid, 0);
            end
            @(negedge s_clk);
            cyc++;
        end
        code_valid = 1'b0;
        i_row_valid = 1'b0;
        if (abort > 0) begin
            s_rst_n = 1'b0;
            #1;
            check_reset_outputs("midrst");
            @(negedge s_clk);
            s_rst_n = 1'b1;
            return;
        end
        check("timeout", cyc < 2000, 1);
        check("out_count", got, exp_n);
        check("rows_sent", sent, total);
        for (int k = 0; k < 3; k++) begin
            #1;
            if (o_layer_done) done++;
            check("idle_busy", o_busy, 0);
            @(negedge s_clk);
        end
        check("done_pulses", done, 1);
    endtask

    initial begin
        s_rst_n = 1'b0;
        repeat (3) @(negedge s_clk);
        #1;
        check_reset_outputs("reset");
        @(negedge s_clk);
        s_rst_n = 1'b1;

        fill_zero();
        img[0][0] = 32'h0000_0001;
        img[0][1] = 32'h0000_0002;
        run_layer(1, 4, 1'b0, 0, 1'b0, 0);

        fill_zero();
        img[0][1] = 32'h0000_0080;
        run_layer(1, 4, 1'b1, 0, 1'b0, 0);

        fill_rand();
        run_layer(1, 4, 1'b0, 1, 1'b0, 0);
        fill_rand();
        run_layer(2, 4, 1'b1, 1, 1'b0, 0);

        fill_rand();
        for (int y = 0; y < 8; y++) begin
            img[0][y] = 32'hFFFF_FFFF;
            img[1][y] = 32'h0000_0000;
        end
        run_layer(3, 2, 1'b0, 2, 1'b1, 0);
        run_layer(3, 2, 1'b1, 2, 1'b1, 0);

        fill_rand();
        for (int m = 0; m < 3; m++)
            for (int y = 0; y < 8; y++) img[m][y] = img[m][y] | 32'hFF00_0000;
        run_layer(1, 6, 1'b0, 2, 1'b1, 0);
        run_layer(2, 6, 1'b1, 2, 1'b1, 0);

        fill_rand();
        run_layer(0, 4, 1'b0, 2, 1'b1, 0);

        for (int t = 0; t < 8; t++) begin
            fill_rand();
            run_layer($urandom_range(1, 3), $urandom_range(1, 4) * 2, $urandom_range(0, 1) == 1,
                      2, 1'b1, 0);
        end

        fill_rand();
        run_layer(1, 8, 1'b1, 0, 1'b0, 3);
        run_layer(1, 8, 1'b1, 2, 1'b1, 0);
        run_layer(1, 8, 1'b0, 0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spike_maxpool_2d_unit.md
SPIKE_MAXPOOL_2D_UNIT -- requirements
Module: spike_maxpool_2d_unit

Interface
REQ-001 SHALL have parameters: IMG_WIDTH, default `IMG_WIDTH, max input columns (even); TIME_STEPS, default `TIME_STEPS, spike bits per pixel; CH_W, default 16, width of the channel counter.
REQ-002 SHALL have ports: s_clk in 1, clock; s_rst_n in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: code_valid in 1, config strobe; conv_in_ch in 16, feature maps per layer; conv_img_size in 16, rows and columns per map (even, 2..IMG_WIDTH); pool_mode in 1, 0 = 2x2 stride 2, 1 = 3x3 stride 2 pad 1.
REQ-004 SHALL have ports: i_row_valid in 1; o_row_ready out 1; i_row_data in IMG_WIDTH*TIME_STEPS, one input row, column c at bits [(c+1)*TIME_STEPS-1 : c*TIME_STEPS].
REQ-005 SHALL have ports: o_pool_valid out 1; i_pool_ready in 1; o_pool_data out (IMG_WIDTH/2)*TIME_STEPS, one pooled row, same column packing; o_busy out 1; o_layer_done out 1, one-cycle pulse.

Function
REQ-006 Pooling SHALL be a per-time-step bitwise OR over the window.
REQ-007 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on code_valid, latching conv_in_ch, conv_img_size and pool_mode; code_valid outside IDLE SHALL be ignored.
REQ-008 A row SHALL transfer on a cycle where i_row_valid && o_row_ready; o_row_ready = (state==RUN) && (!o_pool_valid || i_pool_ready).
REQ-009 Horizontal reduce (combinational): 2x2 output column j = OR of cols 2j and 2j+1; 3x3 output column j = OR of cols 2j-1, 2j and 2j+1, with col -1 treated as zero.
REQ-010 Input columns >= conv_img_size SHALL be masked to zero; output columns >= conv_img_size/2 SHALL be zero.
REQ-011 Row counter r counts 0..conv_img_size-1. On an even r, acc <= acc | hrow. On an odd r, o_pool_data <= acc | hrow and o_pool_valid is set the next cycle (latency 1). Also on an odd r, acc <= hrow in mode 1 (carried into the next window) and acc <= 0 in mode 0.
REQ-012 acc SHALL be cleared at the start of every map, so the zero pad applies to row -1.
REQ-013 o_pool_valid SHALL hold o_pool_data stable until i_pool_ready is sampled high; it then clears unless a new odd row transfers on the same cycle, in which case it stays high with the new data.
REQ-014 After the last row of a map, the channel counter SHALL increment and r wraps to 0. After conv_in_ch maps the FSM goes RUN->DRAIN, then DRAIN->IDLE once o_pool_valid is clear, pulsing o_layer_done for one cycle.
REQ-015 o_busy SHALL be high whenever state != IDLE.
REQ-016 conv_in_ch = 0 SHALL be treated as 1.

Reset
REQ-017 While s_rst_n = 0: state IDLE; o_pool_valid, o_row_ready, o_busy and o_layer_done all 0; o_pool_data, acc, counters and latched config all 0. This SHALL apply mid-operation with no partial output.
REQ-018 The first transfer SHALL be possible on the second s_clk edge after reset release.

Configuration
REQ-019 Macro MAXPOOL_K3_MODE_EN: when defined, mode 1 is supported as specified; when undefined, the 3x3 logic is not synthesised and pool_mode is ignored (always 2x2).

Structure
REQ-020 Shared package/header SHALL hold the mode encodings (POOL_2X2, POOL_3X3), the FSM state encodings and the packed-column slicing width macro.
REQ-021 Sub-module spike_hpool_reduce SHALL hold the combinational horizontal OR and column masking; the FSM, counters, acc and output register stay in the top.

Verification
REQ-022 Mode 0, size 4, TIME_STEPS 4, 1 channel; rows 0..3 cols0 = 4'b0001, 4'b0010, 0, 0, others 0 -> two outputs: col0 = 4'b0011 then 0; one o_layer_done pulse.
REQ-023 Mode 1, size 4; only row 1 col 1 = 4'b1000 -> out row0 col0 = 4'b1000 and col1 = 4'b1000 (column 1 overlaps both windows); out row1 col0 = 4'b1000 (row 1 carried as row 2i-1).
REQ-024 Hold i_pool_ready = 0 for 5 cycles on the first output -> o_pool_data unchanged; o_row_ready low; odd row not accepted until i_pool_ready rises.
REQ-025 conv_in_ch = 3, size 2 -> exactly 3 outputs and 1 o_layer_done; acc does not leak between maps (map 1 all ones, map 2 all zeros -> output 2 is zero).
REQ-026 Assert s_rst_n low after 3 rows of a size-8 map -> all outputs 0 immediately; new code_valid then restarts cleanly from row 0.
REQ-027 Size 6 with IMG_WIDTH 8; ones in input cols 6-7 -> output col 3 = 0.
